// File: rtl/uart_rx_frame_pkg.sv
// Shared constants, receiver state encoding and counter sizing helper for the UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_e;

    // Width of a counter that must hold 0..bit_duration-1.
    function automatic int unsigned cnt_width(input int unsigned bit_duration);
        return (bit_duration < 2) ? 1 : $clog2(bit_duration);
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Frame-level result bundle from the UART receiver to the byte-level command parser.
// Latency: n/a (wires only).
// Backpressure: none; every pulse is single-cycle and must be taken when seen.
// break_det exists only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_frame_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;
`ifdef UART_RX_BREAK_DET_EN
    logic                 break_det;
`endif

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
`ifdef UART_RX_BREAK_DET_EN
        output break_det,
`endif
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input parity_err,
`ifdef UART_RX_BREAK_DET_EN
        input break_det,
`endif
        input busy
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-FF synchroniser, falling-edge detect, bit-phase counter and 3-sample majority vote.
// Latency: 2 cycles of synchronisation; bit_decide/bit_value are combinational at phase HALF+1.
// Backpressure: none; the frame FSM must consume bit_decide in the cycle it is high.
// With UART_RX_BREAK_DET_EN the synchronised line level is also exported.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned BIT_DURATION = 217
) (
    input  logic clk,
    input  logic kill,
    input  logic rx_uart,
    input  logic restart,
    output logic start_edge,
    output logic bit_decide,
`ifdef UART_RX_BREAK_DET_EN
    output logic line_lvl,
`endif
    output logic bit_value
);

    localparam int unsigned HALF = BIT_DURATION / 2;
    localparam int unsigned CW   = cnt_width(BIT_DURATION);

    localparam logic [CW-1:0] PH_LAST = CW'(BIT_DURATION - 1);
    localparam logic [CW-1:0] PH_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] PH_S1   = CW'(HALF);
    localparam logic [CW-1:0] PH_S2   = CW'(HALF + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          dly_q, dly_d;
    logic [CW-1:0] phase_q, phase_d;
    logic          s0_q, s0_d;
    logic          s1_q, s1_d;

    // Synchroniser shift, edge delay, free-running phase and the two early vote samples.
    always_comb begin
        sync1_d = rx_uart;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        if (restart || (phase_q == PH_LAST)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
        s0_d = (phase_q == PH_S0) ? sync2_q : s0_q;
        s1_d = (phase_q == PH_S1) ? sync2_q : s1_q;
    end

    // Line-side registers idle high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (kill) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
            phase_q <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
            phase_q <= phase_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
        end
    end

    assign start_edge = dly_q & ~sync2_q;
    assign bit_decide = (phase_q == PH_S2);
    // Third sample is the live line at HALF+1; the FSM registers the vote at this edge.
    assign bit_value  = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
`ifdef UART_RX_BREAK_DET_EN
    assign line_lvl   = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: data width, parity, 1/2 stop bits, majority-voted bits, error flags.
// Latency: rx_valid pulses one cycle after the last stop-bit decision (phase HALF+2 of that bit).
// Backpressure: none; results are single-cycle pulses with rx_data held until the next frame.
// Optional break detection is enabled with UART_RX_BREAK_DET_EN.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned INPUT_CLK   = 50000000,
    parameter int unsigned BAUD_RATE   = 230400,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = PARITY_NONE,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic            clk,
    input  logic            kill,
    input  logic            rx_uart,
    uart_rx_frame_if.master rx_if
);

    localparam int unsigned BIT_DURATION = (BAUD_RATE == 0) ? 0 : INPUT_CLK / BAUD_RATE;
    localparam int unsigned HALF         = BIT_DURATION / 2;
    localparam int unsigned CW           = cnt_width(BIT_DURATION);

    if (BAUD_RATE == 0 || BIT_DURATION < 8) begin : g_bad_rate
        $error("uart_rx_frame: INPUT_CLK/BAUD_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_rx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE > PARITY_EVEN) begin : g_bad_parity
        $error("uart_rx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end

    rx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           stop_cnt_q, stop_cnt_d;
    logic                 perr_hold_q, perr_hold_d;
    logic                 ferr_hold_q, ferr_hold_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 busy_q, busy_d;
    logic                 start_edge, bit_decide, bit_value;
`ifdef UART_RX_BREAK_DET_EN
    logic                 zero_hold_q, zero_hold_d;
    logic                 break_det_q, break_det_d;
    logic [CW-1:0]        hi_cnt_q, hi_cnt_d;
    logic                 rxs;
`endif

    uart_rx_sampler #(
        .BIT_DURATION (BIT_DURATION)
    ) u_sampler (
        .clk        (clk),
        .kill       (kill),
        .rx_uart    (rx_uart),
        .restart    (start_edge && (state_q == S_IDLE)),
        .start_edge (start_edge),
        .bit_decide (bit_decide),
`ifdef UART_RX_BREAK_DET_EN
        .line_lvl   (rxs),
`endif
        .bit_value  (bit_value)
    );

    // Frame FSM: walks start/data/parity/stop on each bit decision and forms the result pulses.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        rx_data_d    = rx_data_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        perr_hold_d  = perr_hold_q;
        ferr_hold_d  = ferr_hold_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        zero_hold_d  = zero_hold_q;
        break_det_d  = 1'b0;
        hi_cnt_d     = hi_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d     = S_START;
                    perr_hold_d = 1'b0;
                    ferr_hold_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    zero_hold_d = 1'b1;
`endif
                end
            end
            S_START: begin
                // A high vote means the edge was noise: drop back silently.
                if (bit_decide) begin
                    if (bit_value) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (bit_decide) begin
                    shreg_d = {bit_value, shreg_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                    zero_hold_d = zero_hold_q & ~bit_value;
`endif
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        state_d    = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
                        stop_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_decide) begin
                    if (PARITY_MODE == PARITY_ODD) begin
                        perr_hold_d = ~(^shreg_q ^ bit_value);
                    end else begin
                        perr_hold_d = ^shreg_q ^ bit_value;
                    end
`ifdef UART_RX_BREAK_DET_EN
                    zero_hold_d = zero_hold_q & ~bit_value;
`endif
                    state_d    = S_STOP;
                    stop_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (bit_decide) begin
                    ferr_hold_d = ferr_hold_q | ~bit_value;
`ifdef UART_RX_BREAK_DET_EN
                    zero_hold_d = zero_hold_q & ~bit_value;
`endif
                    if (stop_cnt_q == 2'(STOP_BITS - 1)) begin
                        // Re-arm at mid-stop so back-to-back frames are not missed.
                        state_d = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                        if (zero_hold_q && !bit_value) begin
                            break_det_d = 1'b1;
                            hi_cnt_d    = '0;
                            state_d     = S_BREAK;
                        end else begin
`else
                        begin
`endif
                            rx_data_d    = shreg_q;
                            rx_valid_d   = 1'b1;
                            frame_err_d  = ferr_hold_q | ~bit_value;
                            parity_err_d = perr_hold_q;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 2'd1;
                    end
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            S_BREAK: begin
                // Wait for HALF consecutive high cycles before listening again.
                if (!rxs) begin
                    hi_cnt_d = '0;
                end else if (hi_cnt_q == CW'(HALF - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    hi_cnt_d = hi_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // Busy covers the rx_valid cycle even though the FSM is already idle then.
        busy_d = (state_d != S_IDLE) | rx_valid_d;
    end

    // State and output registers; kill wins over any same-cycle frame completion.
    always_ff @(posedge clk) begin
        if (kill) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= '0;
            perr_hold_q  <= 1'b0;
            ferr_hold_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_hold_q  <= 1'b0;
            break_det_q  <= 1'b0;
            hi_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            perr_hold_q  <= perr_hold_d;
            ferr_hold_q  <= ferr_hold_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_BREAK_DET_EN
            zero_hold_q  <= zero_hold_d;
            break_det_q  <= break_det_d;
            hi_cnt_q     <= hi_cnt_d;
`endif
        end
    end

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.busy       = busy_q;
`ifdef UART_RX_BREAK_DET_EN
    assign rx_if.break_det  = break_det_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 instance and a 7E2 instance, both at 217 clocks per bit.
// Frames are driven bit by bit; expectations (data, flags, due cycle) are queued at send time
// and popped by per-instance monitors when rx_valid pulses.
module tb_uart_rx_frame;

    localparam int BD   = 50000000 / 230400;
    localparam int HALF = BD / 2;

    typedef struct {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
        int         due;
    } exp_t;

    logic clk  = 1'b0;
    logic kill = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    int   cyc  = 0;
    int   errors = 0;
    int   checks = 0;
    int   brk_cnt = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame_if #(.DATA_BITS(8)) if_a ();
    uart_rx_frame_if #(.DATA_BITS(7)) if_b ();

    uart_rx_frame #(
        .INPUT_CLK(50000000), .BAUD_RATE(230400), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .kill(kill), .rx_uart(rx_a), .rx_if(if_a)
    );

    uart_rx_frame #(
        .INPUT_CLK(50000000), .BAUD_RATE(230400), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .kill(kill), .rx_uart(rx_b), .rx_if(if_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h required=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors, sampling on the falling edge.
    always @(negedge clk) begin
        if (if_a.rx_valid === 1'b1) begin
            checks++;
            assert (qa.size() != 0) else begin
                errors++;
                $error("FAIL a_unexpected_valid got data=%0h required no pulse", if_a.rx_data);
            end
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                chk("a_data", 32'(if_a.rx_data), 32'(ea.data));
                chk("a_frame_err", 32'(if_a.frame_err), 32'(ea.ferr));
                chk("a_parity_err", 32'(if_a.parity_err), 32'(ea.perr));
                chk("a_latency", 32'(cyc), 32'(ea.due));
                chk("a_busy_on_valid", 32'(if_a.busy), 32'd1);
            end
        end
        if (if_b.rx_valid === 1'b1) begin
            checks++;
            assert (qb.size() != 0) else begin
                errors++;
                $error("FAIL b_unexpected_valid got data=%0h required no pulse", if_b.rx_data);
            end
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                chk("b_data", 32'(if_b.rx_data), 32'(eb.data));
                chk("b_frame_err", 32'(if_b.frame_err), 32'(eb.ferr));
                chk("b_parity_err", 32'(if_b.parity_err), 32'(eb.perr));
                chk("b_latency", 32'(cyc), 32'(eb.due));
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always @(negedge clk) begin
        if (if_a.break_det === 1'b1) brk_cnt++;
    end
`endif

    task automatic set_line(input bit on_b, input logic v);
        if (on_b) rx_b = v;
        else rx_a = v;
    endtask

    // One bit time; optionally with a one-cycle inverted spike near the vote window.
    task automatic bit_time(input bit on_b, input logic v, input bit spike);
        set_line(on_b, v);
        if (spike) begin
            repeat (HALF + 1) @(posedge clk);
            #1 set_line(on_b, ~v);
            @(posedge clk);
            #1 set_line(on_b, v);
            repeat (BD - HALF - 2) @(posedge clk);
            #1;
        end else begin
            repeat (BD) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit on_b, input logic [8:0] data, input int nd, input int pmode,
                              input bit bad_par, input int nstop, input logic last_stop,
                              input int spike_bit, input int gap);
        logic       par;
        logic [8:0] mask;
        int         nbits;
        exp_t       e;
        par = 1'b0;
        for (int i = 0; i < nd; i++) par ^= data[i];
        if (pmode == 1) par = ~par;
        if (bad_par) par = ~par;
        nbits = 1 + nd + ((pmode != 0) ? 1 : 0) + nstop;
        mask = 9'((1 << nd) - 1);
        @(posedge clk);
        #1;
        e.data = data & mask;
        e.ferr = ~last_stop;
        e.perr = bad_par;
        e.due  = cyc + (nbits - 1) * BD + HALF + 5;
        if (on_b) qb.push_back(e);
        else qa.push_back(e);
        bit_time(on_b, 1'b0, spike_bit == 0);
        for (int i = 0; i < nd; i++) bit_time(on_b, data[i], spike_bit == i + 1);
        if (pmode != 0) bit_time(on_b, par, 1'b0);
        for (int s = 0; s < nstop; s++) bit_time(on_b, (s == nstop - 1) ? last_stop : 1'b1, 1'b0);
        set_line(on_b, 1'b1);
        repeat (gap) @(posedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 4 * BD) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 32'(qa.size() + qb.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        chk("rst_a_valid", 32'(if_a.rx_valid), 32'd0);
        chk("rst_a_data", 32'(if_a.rx_data), 32'd0);
        chk("rst_a_ferr", 32'(if_a.frame_err), 32'd0);
        chk("rst_a_perr", 32'(if_a.parity_err), 32'd0);
        chk("rst_a_busy", 32'(if_a.busy), 32'd0);
        chk("rst_b_data", 32'(if_b.rx_data), 32'd0);
        chk("rst_b_busy", 32'(if_b.busy), 32'd0);
        repeat (BD) @(posedge clk);

        // Basic 8N1 frame with latency check
        send_frame(1'b0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, -1, 2 * BD);
        drain("drain_a5");

        // One-cycle glitch: seen as a start, then rejected
        @(posedge clk);
        #1 rx_a = 1'b0;
        @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("glitch_busy_seen", 32'(if_a.busy), 32'd1);
        repeat (2 * BD) @(posedge clk);
        #1 chk("glitch_busy_clear", 32'(if_a.busy), 32'd0);

        // Low pulse ending before the vote window
        rx_a = 1'b0;
        repeat (HALF - 10) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (2 * BD) @(posedge clk);
        #1 chk("short_busy_clear", 32'(if_a.busy), 32'd0);

        // Valid frame after noise, then back-to-back frame
        send_frame(1'b0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, -1, 0);
        send_frame(1'b0, 9'h0C3, 8, 0, 1'b0, 1, 1'b1, -1, BD);
        drain("drain_3c_c3");
        chk("prekill_data", 32'(if_a.rx_data), 32'h0C3);

        // kill at data bit 4 of 0xFF
        @(posedge clk);
        #1 rx_a = 1'b0;
        repeat (BD) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (4 * BD + HALF) @(posedge clk);
        #1 chk("kill_busy_before", 32'(if_a.busy), 32'd1);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        chk("kill_data", 32'(if_a.rx_data), 32'd0);
        chk("kill_busy", 32'(if_a.busy), 32'd0);
        chk("kill_valid", 32'(if_a.rx_valid), 32'd0);
        repeat (6 * BD) @(posedge clk);

        // Spike on data bit 3 of 0x00, then a clean 0x81
        send_frame(1'b0, 9'h000, 8, 0, 1'b0, 1, 1'b1, 4, BD);
        send_frame(1'b0, 9'h081, 8, 0, 1'b0, 1, 1'b1, -1, BD);
        drain("drain_00_81");

        // 12 bit times low
        @(posedge clk);
        #1;
`ifndef UART_RX_BREAK_DET_EN
        ea.data = 9'h000;
        ea.ferr = 1'b1;
        ea.perr = 1'b0;
        ea.due  = cyc + 9 * BD + HALF + 5;
        qa.push_back(ea);
`endif
        rx_a = 1'b0;
        repeat (12 * BD) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (2 * BD) @(posedge clk);
        drain("drain_break");
`ifdef UART_RX_BREAK_DET_EN
        chk("break_pulses", 32'(brk_cnt), 32'd1);
        chk("break_keeps_data", 32'(if_a.rx_data), 32'h081);
`endif

        // 7E2 instance: bad parity, low second stop, clean frame
        send_frame(1'b1, 9'h055, 7, 2, 1'b1, 2, 1'b1, -1, BD);
        send_frame(1'b1, 9'h033, 7, 2, 1'b0, 2, 1'b0, -1, BD);
        send_frame(1'b1, 9'h00F, 7, 2, 1'b0, 2, 1'b1, -1, BD);
        drain("drain_b");
        #1 chk("final_b_busy", 32'(if_b.busy), 32'd0);
        chk("final_a_busy", 32'(if_a.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog expired at cycle %0d required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
